// File: rtl/rv32_dbg_pkg.sv
// rtl/rv32_dbg_pkg.sv - shared types for the rv32 register-file dump reader
package rv32_dbg_pkg;

    localparam int REG_COUNT = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        HOLD,
        DONE
    } dump_state_t;

endpackage

// File: rtl/rv32_regs_dump.sv
// rtl/rv32_regs_dump.sv - walks regfile read port, streams {index, value}, XOR checksum
module rv32_regs_dump
    import rv32_dbg_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_in,
    input  logic            abort_in,
    input  logic            grant_in,
    output logic            busy_out,
    output logic [4:0]      reg_addr_out,
    input  logic [XLEN-1:0] reg_value_in,
    output logic            dump_valid_out,
    input  logic            dump_ready_in,
    output logic [4:0]      dump_index_out,
    output logic [XLEN-1:0] dump_data_out,
    output logic            done_out,
    output logic [XLEN-1:0] checksum_out
);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= REG_COUNT) begin : g_bad_range
            $error("rv32_regs_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam reg_idx_t FIRST_IDX = reg_idx_t'(FIRST_REG);
    localparam reg_idx_t LAST_IDX  = reg_idx_t'(LAST_REG);

    dump_state_t     state, state_nxt;
    reg_idx_t        idx, idx_nxt;
    logic [XLEN-1:0] csum_nxt;
    logic            accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= FIRST_IDX;
            checksum_out <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            checksum_out <= csum_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        csum_nxt       = checksum_out;
        busy_out       = (state != IDLE);
        reg_addr_out   = FIRST_IDX;
        dump_valid_out = 1'b0;
        dump_index_out = '0;
        dump_data_out  = '0;
        done_out       = 1'b0;
        accept         = 1'b0;

        case (state)
            IDLE: begin
                if (req_in) begin
                    state_nxt = grant_in ? PRIME : HOLD;
                    idx_nxt   = FIRST_IDX;
                    csum_nxt  = '0;
                end
            end
            PRIME: begin
                reg_addr_out = idx;
                state_nxt    = grant_in ? STREAM : HOLD;
            end
            STREAM: begin
                // Valid is gated so a lost grant or an abort never transfers a beat.
                dump_valid_out = grant_in && !abort_in;
                dump_index_out = idx;
                dump_data_out  = reg_value_in;
                accept         = dump_valid_out && dump_ready_in;
                // Look ahead one address on accept so the next beat's data is ready.
                reg_addr_out   = accept ? idx + 5'd1 : idx;
                if (!grant_in) begin
                    state_nxt = HOLD;
                end else if (accept) begin
                    csum_nxt = checksum_out ^ reg_value_in;
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            HOLD: begin
                reg_addr_out = idx;
                if (grant_in) begin
                    state_nxt = PRIME;
                end
            end
            DONE: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort_in && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_rv32_regs_dump.sv
// tb/tb_rv32_regs_dump.sv - directed self-checking bench for rv32_regs_dump
module tb_rv32_regs_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req, req2, abort, grant, ready;
    logic        busy, valid, done;
    logic [4:0]  addr, index;
    logic [31:0] data, csum, value;
    logic        busy2, valid2, done2;
    logic [4:0]  addr2, index2;
    logic [31:0] data2, csum2, value2;

    logic [31:0] regs [32];
    logic [4:0]  raddr  = 5'd0;
    logic [4:0]  raddr2 = 5'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        raddr  <= addr;
        raddr2 <= addr2;
    end
    assign value  = regs[raddr];
    assign value2 = regs[raddr2];

    rv32_regs_dump u_dut (
        .clk(clk), .reset(reset), .req_in(req), .abort_in(abort), .grant_in(grant),
        .busy_out(busy), .reg_addr_out(addr), .reg_value_in(value),
        .dump_valid_out(valid), .dump_ready_in(ready), .dump_index_out(index),
        .dump_data_out(data), .done_out(done), .checksum_out(csum)
    );

    rv32_regs_dump #(.XLEN(32), .FIRST_REG(4), .LAST_REG(4)) u_one (
        .clk(clk), .reset(reset), .req_in(req2), .abort_in(abort), .grant_in(grant),
        .busy_out(busy2), .reg_addr_out(addr2), .reg_value_in(value2),
        .dump_valid_out(valid2), .dump_ready_in(ready), .dump_index_out(index2),
        .dump_data_out(data2), .done_out(done2), .checksum_out(csum2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Registers hold 0x1000+i, x0 reads zero.
    function automatic logic [31:0] exp_val(input int k);
        return (k == 0) ? 32'h0 : 32'h1000 + k;
    endfunction

    task automatic start();
        req = 1'b1;
        step();
        req = 1'b0;
        #1;
        chk("prime_busy", {31'b0, busy}, 32'd1);
        chk("prime_valid", {31'b0, valid}, 32'd0);
        step();
    endtask

    task automatic beat(input string tag, input int k);
        chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
        chk({tag, "_index"}, {27'b0, index}, k);
        chk({tag, "_data"}, data, exp_val(k));
        step();
    endtask

    task automatic finish_check(input string tag);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_csum"}, csum, 32'h0000_1000);
        step();
        chk({tag, "_done_gone"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        chk({tag, "_csum_held"}, csum, 32'h0000_1000);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = exp_val(i);
        req = 1'b0; req2 = 1'b0; abort = 1'b0; grant = 1'b1; ready = 1'b1;

        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_csum", csum, 32'd0);
        chk("rst_addr", {27'b0, addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Full back-to-back dump
        start();
        for (int k = 0; k < 32; k++) beat("b2b", k);
        finish_check("b2b");

        // Sink stalls three cycles on beat 5
        start();
        for (int k = 0; k < 32; k++) begin
            if (k == 5) begin
                ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("stall_valid", {31'b0, valid}, 32'd1);
                    chk("stall_index", {27'b0, index}, 32'd5);
                    chk("stall_data", data, 32'h0000_1005);
                    chk("stall_addr", {27'b0, addr}, 32'd5);
                    step();
                end
                ready = 1'b1;
                #1;
                chk("stall_release_addr", {27'b0, addr}, 32'd6);
            end
            beat("stall", k);
        end
        finish_check("stall");

        // Grant dropped at beat 10 for four cycles
        start();
        for (int k = 0; k < 10; k++) beat("grant", k);
        grant = 1'b0;
        #1;
        chk("grant_gate_valid", {31'b0, valid}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("hold_valid", {31'b0, valid}, 32'd0);
            chk("hold_busy", {31'b0, busy}, 32'd1);
        end
        step();
        grant = 1'b1;
        step();
        chk("reprime_valid", {31'b0, valid}, 32'd0);
        chk("reprime_addr", {27'b0, addr}, 32'd10);
        step();
        for (int k = 10; k < 32; k++) beat("grant", k);
        finish_check("grant");

        // Abort on beat 7: partial checksum 0x1001^..^0x1006 = 0x7
        start();
        for (int k = 0; k < 7; k++) beat("abort", k);
        abort = 1'b1;
        ready = 1'b0;
        step();
        abort = 1'b0;
        ready = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_csum", csum, 32'h0000_0007);
        start();
        chk("restart_csum", csum, 32'd0);
        for (int k = 0; k < 32; k++) begin
            req = (k == 15);
            beat("restart", k);
        end
        req = 1'b0;
        finish_check("restart");

        // Asynchronous reset mid-stream
        start();
        for (int k = 0; k < 3; k++) beat("reset", k);
        reset = 1'b1;
        #1;
        chk("areset_busy", {31'b0, busy}, 32'd0);
        chk("areset_valid", {31'b0, valid}, 32'd0);
        chk("areset_data", data, 32'd0);
        chk("areset_index", {27'b0, index}, 32'd0);
        chk("areset_csum", csum, 32'd0);
        chk("areset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_reset_idle", {31'b0, busy}, 32'd0);

        // Single-beat instance FIRST_REG = LAST_REG = 4
        regs[4] = 32'hDEAD_BEEF;
        req2 = 1'b1;
        step();
        req2 = 1'b0;
        #1;
        chk("one_prime_valid", {31'b0, valid2}, 32'd0);
        step();
        chk("one_valid", {31'b0, valid2}, 32'd1);
        chk("one_index", {27'b0, index2}, 32'd4);
        chk("one_data", data2, 32'hDEAD_BEEF);
        step();
        chk("one_done", {31'b0, done2}, 32'd1);
        chk("one_csum", csum2, 32'hDEAD_BEEF);
        step();
        chk("one_idle", {31'b0, busy2}, 32'd0);
        chk("one_done_gone", {31'b0, done2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
